// File: rtl/cpu16_pkg.sv
// Shared types and sizes for the 16-bit CPU datapath.
package cpu16_pkg;

  localparam int XLEN      = 16;
  localparam int NREGS     = 16;
  localparam int REG_IDX_W = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      word_t;

  // One-hot mask selecting register idx within an NREGS-wide vector.
  function automatic logic [NREGS-1:0] idx_onehot(input reg_idx_t idx);
    logic [NREGS-1:0] one;
    one = {{(NREGS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/milan_scoreboard.sv
// Per-register busy scoreboard: set on accepted issue, cleared on writeback,
// and a combinational stall computed from the registered busy bits only.
module milan_scoreboard
  import cpu16_pkg::*;
#(
  parameter bit ZERO_X0 = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  reg_idx_t         wr_addr_i,
  input  logic             iss_en_i,
  input  logic             iss_rd_en_i,
  input  reg_idx_t         iss_rd_i,
  input  reg_idx_t         rs1_i,
  input  reg_idx_t         rs2_i,
  output logic             stall_o,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             rs_hit;
  logic             rd_hit;
  logic             stall;
  logic             accept;
  logic             set_ok;

  // Hazard detection and next busy state; a set is applied after the clear
  // so an issue that targets the register being written back keeps it busy.
  always_comb begin
    busy_d = busy_q;
    rs_hit = busy_q[rs1_i] | busy_q[rs2_i];
    rd_hit = iss_rd_en_i & busy_q[iss_rd_i];
    stall  = iss_en_i & (rs_hit | rd_hit);
    accept = iss_en_i & ~stall;
    set_ok = accept & iss_rd_en_i & ~(ZERO_X0 && (iss_rd_i == 4'd0));

    if (wr_en_i) begin
      busy_d = busy_d & ~idx_onehot(wr_addr_i);
    end else begin
      busy_d = busy_d;
    end

    if (set_ok) begin
      busy_d = busy_d | idx_onehot(iss_rd_i);
    end else begin
      busy_d = busy_d;
    end

    if (ZERO_X0) begin
      busy_d[0] = 1'b0;
    end else begin
      busy_d[0] = busy_d[0];
    end
  end

  // Busy flops with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= {NREGS{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign stall_o = stall;
  assign busy_o  = busy_q;

endmodule

// File: rtl/milan_regfile.sv
// 16 x 16-bit architectural register file with one writeback port and a
// busy scoreboard; every register is presented directly from its flop.
module milan_regfile
  import cpu16_pkg::*;
#(
  parameter bit    ZERO_X0   = 1'b1,
  parameter word_t RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        iss_en,
  input  logic        iss_rd_en,
  input  logic [3:0]  iss_rd,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  output logic        stall,
  output logic [15:0] busy,
  output logic [15:0] x0,
  output logic [15:0] x1,
  output logic [15:0] x2,
  output logic [15:0] x3,
  output logic [15:0] x4,
  output logic [15:0] x5,
  output logic [15:0] x6,
  output logic [15:0] x7,
  output logic [15:0] x8,
  output logic [15:0] x9,
  output logic [15:0] x10,
  output logic [15:0] x11,
  output logic [15:0] x12,
  output logic [15:0] x13,
  output logic [15:0] x14,
  output logic [15:0] x15
);

  word_t regs_q [NREGS];
  word_t regs_d [NREGS];
  logic  wr_drop;

  milan_scoreboard #(
    .ZERO_X0 (ZERO_X0)
  ) u_scoreboard (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .iss_en_i    (iss_en),
    .iss_rd_en_i (iss_rd_en),
    .iss_rd_i    (iss_rd),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .stall_o     (stall),
    .busy_o      (busy)
  );

  // Writeback data path; writes to a hardwired-zero x0 are discarded.
  always_comb begin
    regs_d  = regs_q;
    wr_drop = ZERO_X0 && (wr_addr == 4'd0);
    if (wr_en && !wr_drop) begin
      regs_d[wr_addr] = wr_data;
    end else begin
      regs_d[wr_addr] = regs_q[wr_addr];
    end
  end

  // Register array; reset overrides any writeback in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (ZERO_X0 && (i == 0)) ? 16'h0000 : RESET_VAL;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign x0  = regs_q[0];
  assign x1  = regs_q[1];
  assign x2  = regs_q[2];
  assign x3  = regs_q[3];
  assign x4  = regs_q[4];
  assign x5  = regs_q[5];
  assign x6  = regs_q[6];
  assign x7  = regs_q[7];
  assign x8  = regs_q[8];
  assign x9  = regs_q[9];
  assign x10 = regs_q[10];
  assign x11 = regs_q[11];
  assign x12 = regs_q[12];
  assign x13 = regs_q[13];
  assign x14 = regs_q[14];
  assign x15 = regs_q[15];

endmodule

// File: tb/tb_milan_regfile.sv
// Directed, table-driven bench for milan_regfile (default and non-zero-x0 builds).
module tb_milan_regfile;

  typedef struct {
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        iss_en;
    logic        iss_rd_en;
    logic [3:0]  iss_rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        exp_stall;
    logic [15:0] exp_busy;
    logic [3:0]  chk;
    logic [15:0] exp_x;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, wr_en, iss_en, iss_rd_en;
  logic [3:0]  wr_addr, iss_rd, rs1, rs2;
  logic [15:0] wr_data;
  logic        stall0, stall1;
  logic [15:0] busy0, busy1;
  logic [15:0] xa [16];
  logic [15:0] xb [16];

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  milan_regfile dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_rd_en(iss_rd_en), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .stall(stall0), .busy(busy0),
    .x0(xa[0]), .x1(xa[1]), .x2(xa[2]), .x3(xa[3]), .x4(xa[4]), .x5(xa[5]),
    .x6(xa[6]), .x7(xa[7]), .x8(xa[8]), .x9(xa[9]), .x10(xa[10]), .x11(xa[11]),
    .x12(xa[12]), .x13(xa[13]), .x14(xa[14]), .x15(xa[15])
  );

  milan_regfile #(.ZERO_X0(1'b0), .RESET_VAL(16'h5A5A)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_rd_en(iss_rd_en), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .stall(stall1), .busy(busy1),
    .x0(xb[0]), .x1(xb[1]), .x2(xb[2]), .x3(xb[3]), .x4(xb[4]), .x5(xb[5]),
    .x6(xb[6]), .x7(xb[7]), .x8(xb[8]), .x9(xb[9]), .x10(xb[10]), .x11(xb[11]),
    .x12(xb[12]), .x13(xb[13]), .x14(xb[14]), .x15(xb[15])
  );

  function automatic vec_t mk(input logic r, input logic we, input logic [3:0] wa,
                              input logic [15:0] wd, input logic ie, input logic ire,
                              input logic [3:0] ird, input logic [3:0] s1, input logic [3:0] s2,
                              input logic es, input logic [15:0] eb, input logic [3:0] c,
                              input logic [15:0] ex);
    vec_t v;
    v.rst = r; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.iss_en = ie; v.iss_rd_en = ire; v.iss_rd = ird; v.rs1 = s1; v.rs2 = s2;
    v.exp_stall = es; v.exp_busy = eb; v.chk = c; v.exp_x = ex;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic ie, input logic ire, input logic [3:0] ird,
                       input logic [3:0] s1, input logic [3:0] s2);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_rd_en = ire; iss_rd = ird; rs1 = s1; rs2 = s2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);

    //         rst  wen  wa     wd         ien  rde  rd     rs1    rs2    stall busy        chk    x
    vecs.push_back(mk(1'b1,1'b0,4'd0, 16'h0000,1'b0,1'b0,4'd0, 4'd0, 4'd0, 1'b0,16'h0000,4'd5, 16'h0000));
    vecs.push_back(mk(1'b0,1'b1,4'd5, 16'hA5A5,1'b0,1'b0,4'd0, 4'd0, 4'd0, 1'b0,16'h0000,4'd5, 16'hA5A5));
    vecs.push_back(mk(1'b0,1'b1,4'd0, 16'hFFFF,1'b0,1'b0,4'd0, 4'd0, 4'd0, 1'b0,16'h0000,4'd0, 16'h0000));
    vecs.push_back(mk(1'b0,1'b0,4'd0, 16'h0000,1'b1,1'b1,4'd0, 4'd1, 4'd2, 1'b0,16'h0000,4'd0, 16'h0000));
    vecs.push_back(mk(1'b0,1'b0,4'd0, 16'h0000,1'b1,1'b0,4'd0, 4'd0, 4'd0, 1'b0,16'h0000,4'd0, 16'h0000));
    vecs.push_back(mk(1'b0,1'b0,4'd0, 16'h0000,1'b1,1'b1,4'd3, 4'd1, 4'd2, 1'b0,16'h0008,4'd3, 16'h0000));
    vecs.push_back(mk(1'b0,1'b1,4'd3, 16'h3333,1'b1,1'b0,4'd0, 4'd1, 4'd3, 1'b1,16'h0000,4'd3, 16'h3333));
    vecs.push_back(mk(1'b0,1'b0,4'd0, 16'h0000,1'b1,1'b0,4'd0, 4'd1, 4'd3, 1'b0,16'h0000,4'd3, 16'h3333));
    vecs.push_back(mk(1'b0,1'b1,4'd7, 16'h7777,1'b1,1'b1,4'd7, 4'd1, 4'd2, 1'b0,16'h0080,4'd7, 16'h7777));
    vecs.push_back(mk(1'b0,1'b0,4'd0, 16'h0000,1'b1,1'b1,4'd9, 4'd1, 4'd2, 1'b0,16'h0280,4'd9, 16'h0000));
    vecs.push_back(mk(1'b0,1'b0,4'd0, 16'h0000,1'b1,1'b1,4'd9, 4'd1, 4'd2, 1'b1,16'h0280,4'd9, 16'h0000));
    vecs.push_back(mk(1'b0,1'b0,4'd0, 16'h0000,1'b1,1'b1,4'd10,4'd7, 4'd2, 1'b1,16'h0280,4'd10,16'h0000));
    vecs.push_back(mk(1'b0,1'b1,4'd9, 16'h9999,1'b0,1'b0,4'd0, 4'd0, 4'd0, 1'b0,16'h0080,4'd9, 16'h9999));
    vecs.push_back(mk(1'b0,1'b1,4'd7, 16'h0707,1'b1,1'b0,4'd0, 4'd7, 4'd0, 1'b1,16'h0000,4'd7, 16'h0707));
    vecs.push_back(mk(1'b0,1'b1,4'd4, 16'h1234,1'b0,1'b0,4'd0, 4'd0, 4'd0, 1'b0,16'h0000,4'd4, 16'h1234));
    vecs.push_back(mk(1'b0,1'b0,4'd0, 16'h0000,1'b1,1'b1,4'd4, 4'd1, 4'd2, 1'b0,16'h0010,4'd4, 16'h1234));
    vecs.push_back(mk(1'b0,1'b0,4'd0, 16'h0000,1'b1,1'b1,4'd10,4'd1, 4'd2, 1'b0,16'h0410,4'd4, 16'h1234));
    vecs.push_back(mk(1'b1,1'b1,4'd4, 16'hBEEF,1'b1,1'b1,4'd5, 4'd1, 4'd2, 1'b0,16'h0000,4'd4, 16'h0000));
    vecs.push_back(mk(1'b0,1'b1,4'd4, 16'h5678,1'b0,1'b0,4'd0, 4'd0, 4'd0, 1'b0,16'h0000,4'd4, 16'h5678));
    vecs.push_back(mk(1'b0,1'b0,4'd0, 16'h0000,1'b1,1'b1,4'd2, 4'd1, 4'd3, 1'b0,16'h0004,4'd2, 16'h0000));
    vecs.push_back(mk(1'b0,1'b0,4'd0, 16'h0000,1'b0,1'b0,4'd0, 4'd2, 4'd2, 1'b0,16'h0004,4'd2, 16'h0000));
    vecs.push_back(mk(1'b0,1'b0,4'd0, 16'h0000,1'b1,1'b1,4'd2, 4'd0, 4'd0, 1'b1,16'h0004,4'd2, 16'h0000));
    vecs.push_back(mk(1'b0,1'b0,4'd0, 16'h0000,1'b1,1'b0,4'd2, 4'd1, 4'd3, 1'b0,16'h0004,4'd2, 16'h0000));

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].wr_en, vecs[k].wr_addr, vecs[k].wr_data, vecs[k].iss_en,
            vecs[k].iss_rd_en, vecs[k].iss_rd, vecs[k].rs1, vecs[k].rs2);
      #1;
      check($sformatf("vec%0d_stall", k), {15'd0, stall0}, {15'd0, vecs[k].exp_stall});
      tick();
      check($sformatf("vec%0d_busy", k), busy0, vecs[k].exp_busy);
      check($sformatf("vec%0d_x%0d", k, vecs[k].chk), xa[vecs[k].chk], vecs[k].exp_x);
    end

    // Reset state of every register, then one write per register.
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    check("rst_busy", busy0, 16'h0000);
    for (int i = 0; i < 16; i++) check($sformatf("rst_x%0d", i), xa[i], 16'h0000);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] a;
      a = 4'(i);
      drive(1'b0, 1'b1, a, {4{a}} ^ 16'h0F0F, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] a;
      a = 4'(i);
      check($sformatf("fill_x%0d", i), xa[i], (i == 0) ? 16'h0000 : ({4{a}} ^ 16'h0F0F));
    end

    // Build with ZERO_X0=0 and a non-zero reset value.
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    check("nz_rst_x0", xb[0], 16'h5A5A);
    check("nz_rst_x3", xb[3], 16'h5A5A);
    check("z_rst_x3", xa[3], 16'h0000);
    drive(1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    check("nz_wr_x0", xb[0], 16'hFFFF);
    check("z_wr_x0", xa[0], 16'h0000);
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 4'd0, 4'd1, 4'd2);
    tick();
    check("nz_busy_x0", busy1, 16'h0001);
    check("z_busy_x0", busy0, 16'h0000);
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd0, 4'd0, 4'd5);
    #1;
    check("nz_stall_rs0", {15'd0, stall1}, 16'h0001);
    check("z_stall_rs0", {15'd0, stall0}, 16'h0000);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
